// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared constants, state encoding and CRC step for the 10BASE-T receiver
package eth_rx_pkg;

    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam int unsigned LEN_W           = 11;

    // ST_SKIP: frame aborted for length; swallow bits until the carrier drops
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } rx_state_e;

    // One bit of the MSB-first CRC-32 register, bits fed in line order
    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
        crc_step = {crc[30:0], 1'b0} ^ ({32{b ^ crc[31]}} & ETH_CRC_POLY);
    endfunction

endpackage

// File: rtl/eth_rx_mdec.sv
// rtl/eth_rx_mdec.sv - Manchester bit recovery: rx synchroniser, edge timer, blanking window
//  i_clk, i_rst_n     clock, asynchronous active-low reset
//  i_rx               raw line input
//  o_bit              recovered bit (line level after the mid-bit edge), valid with o_bit_stb
//  o_bit_stb          one-cycle strobe per recovered bit
//  o_carrier_lost     one-cycle strobe when no mid-bit edge arrived in time
module eth_rx_mdec #(
    parameter int HALF_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_bit,
    output logic o_bit_stb,
    output logic o_carrier_lost
);

    localparam int unsigned BLANK = (3 * HALF_BIT) / 2;
    localparam int unsigned LOST  = 3 * HALF_BIT;
    localparam int unsigned TW    = $clog2(LOST + 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    logic          r_active;
    logic [TW-1:0] r_timer;

    logic w_edge;
    logic w_in_window;
    logic w_accept;
    logic w_lost;

    assign w_edge      = r_sync[1] ^ r_prev;
    assign w_in_window = (r_timer >= TW'(BLANK)) && (r_timer < TW'(LOST));
    // While inactive the first edge seen is trusted as a mid-bit edge
    assign w_accept    = w_edge && (!r_active || w_in_window);
    assign w_lost      = r_active && !w_accept && (r_timer == TW'(LOST));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= 2'b00;
            r_prev   <= 1'b0;
            r_active <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= r_sync[1];
            if (w_accept) begin
                r_active <= 1'b1;
                r_timer  <= '0;
            end else if (w_lost) begin
                r_active <= 1'b0;
                r_timer  <= '0;
            end else if (r_active) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign o_bit          = r_sync[1];
    assign o_bit_stb      = w_accept;
    assign o_carrier_lost = w_lost;

endmodule

// File: rtl/eth_rx.sv
// rtl/eth_rx.sv - 10BASE-T receiver: SFD hunt, byte assembly, FCS check, length, link pulses
//  i_clk, i_rst_n     clock, asynchronous active-low reset
//  i_rx               raw Manchester line input
//  o_rx_data/valid    received byte and its one-cycle strobe (FCS bytes included)
//  o_rx_sof           with o_rx_valid of the first byte after SFD
//  o_rx_eof           end-of-frame strobe; o_rx_crc_ok, o_rx_err, o_rx_len valid with it
//  o_link_pulse       one-cycle strobe per normal link pulse
module eth_rx
    import eth_rx_pkg::*;
#(
    parameter int HALF_BIT = 4,
    parameter int MAX_LEN  = 1518
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    output logic [7:0]       o_rx_data,
    output logic             o_rx_valid,
    output logic             o_rx_sof,
    output logic             o_rx_eof,
    output logic             o_rx_crc_ok,
    output logic             o_rx_err,
    output logic [LEN_W-1:0] o_rx_len,
    output logic             o_link_pulse
);

    logic w_bit;
    logic w_bit_stb;
    logic w_lost;

    eth_rx_mdec #(.HALF_BIT(HALF_BIT)) u_mdec (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx           (i_rx),
        .o_bit          (w_bit),
        .o_bit_stb      (w_bit_stb),
        .o_carrier_lost (w_lost)
    );

    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [6:0]       r_sr;        // last 7 hunted bits
    logic [1:0]       r_hunt_cnt;  // bits decoded since IDLE, saturating at 2
    logic [6:0]       r_byte;      // partial byte, LSB-first
    logic [2:0]       r_bitcnt;
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_sof;
    logic             r_rx_eof;
    logic             r_rx_crc_ok;
    logic             r_rx_err;
    logic             r_link_pulse;

    logic [7:0] w_hunt_sr;
    logic [7:0] w_byte_nxt;
    logic       w_byte_done;
    logic       w_oversize;

    assign w_hunt_sr   = {w_bit, r_sr};
    assign w_byte_nxt  = {w_bit, r_byte};
    assign w_byte_done = (r_state == ST_DATA) && w_bit_stb && (r_bitcnt == 3'd7);
    assign w_oversize  = w_byte_done && (r_len == LEN_W'(MAX_LEN));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_bit_stb) w_state_nxt = ST_HUNT;
            ST_HUNT: begin
                if (w_lost)                                     w_state_nxt = ST_IDLE;
                else if (w_bit_stb && (w_hunt_sr == ETH_SFD))   w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_lost)          w_state_nxt = ST_IDLE;
                else if (w_oversize) w_state_nxt = ST_SKIP;
            end
            ST_SKIP: if (w_lost) w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr         <= '0;
            r_hunt_cnt   <= '0;
            r_byte       <= '0;
            r_bitcnt     <= '0;
            r_crc        <= ETH_CRC_INIT;
            r_len        <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_rx_eof     <= 1'b0;
            r_rx_crc_ok  <= 1'b0;
            r_rx_err     <= 1'b0;
            r_link_pulse <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_rx_sof     <= 1'b0;
            r_rx_eof     <= 1'b0;
            r_rx_crc_ok  <= 1'b0;
            r_rx_err     <= 1'b0;
            r_link_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_bit_stb) begin
                        r_sr       <= {w_bit, 6'd0};
                        r_hunt_cnt <= 2'd1;
                    end
                end
                ST_HUNT: begin
                    if (w_bit_stb) begin
                        r_sr <= w_hunt_sr[7:1];
                        if (r_hunt_cnt != 2'd2) r_hunt_cnt <= r_hunt_cnt + 2'd1;
                        if (w_hunt_sr == ETH_SFD) begin
                            r_crc    <= ETH_CRC_INIT;
                            r_bitcnt <= '0;
                            r_len    <= '0;
                        end
                    end
                    // A lone edge followed by silence is a link pulse, not a frame
                    if (w_lost && (r_hunt_cnt <= 2'd1)) r_link_pulse <= 1'b1;
                end
                ST_DATA: begin
                    if (w_bit_stb) begin
                        r_crc    <= crc_step(r_crc, w_bit);
                        r_byte   <= w_byte_nxt[7:1];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_oversize) begin
                            r_rx_eof <= 1'b1;
                            r_rx_err <= 1'b1;
                        end else if (r_bitcnt == 3'd7) begin
                            r_rx_data  <= w_byte_nxt;
                            r_rx_valid <= 1'b1;
                            r_rx_sof   <= (r_len == '0);
                            if (r_len != {LEN_W{1'b1}}) r_len <= r_len + 1'b1;
                        end
                    end
                    if (w_lost) begin
                        r_rx_eof    <= 1'b1;
                        r_rx_err    <= (r_bitcnt != 3'd0);
                        r_rx_crc_ok <= (r_crc == ETH_CRC_RESIDUE) && (r_bitcnt == 3'd0)
                                       && (r_len >= LEN_W'(5));
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_rx_sof     = r_rx_sof;
    assign o_rx_eof     = r_rx_eof;
    assign o_rx_crc_ok  = r_rx_crc_ok;
    assign o_rx_err     = r_rx_err;
    assign o_rx_len     = r_len;
    assign o_link_pulse = r_link_pulse;

endmodule

// File: tb/tb_eth_rx.sv
// tb/tb_eth_rx.sv - randomized self-checking bench for eth_rx against a byte-level frame model
module tb_eth_rx;

    localparam int HALF_BIT = 4;
    localparam int MAX_LEN  = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, link_pulse;
    logic [10:0] rx_len;

    always #5 clk = ~clk;

    eth_rx #(.HALF_BIT(HALF_BIT), .MAX_LEN(MAX_LEN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx         (rx),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_rx_sof     (rx_sof),
        .o_rx_eof     (rx_eof),
        .o_rx_crc_ok  (rx_crc_ok),
        .o_rx_err     (rx_err),
        .o_rx_len     (rx_len),
        .o_link_pulse (link_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collect what the receiver delivers
    byte unsigned rx_q[$];
    int           sof_bad = 0;
    int           eof_cnt = 0;
    int           lp_cnt = 0;
    int           overlap_cnt = 0;
    logic [10:0]  eof_len = '0;
    logic         eof_ok = 1'b0;
    logic         eof_err = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_sof != (rx_q.size() == 0)) sof_bad++;
            rx_q.push_back(rx_data);
        end
        if (rx_eof) begin
            eof_cnt++;
            eof_len = rx_len;
            eof_ok  = rx_crc_ok;
            eof_err = rx_err;
        end
        if (link_pulse) lp_cnt++;
        if (rx_valid && rx_eof) overlap_cnt++;
    end

    // Reference: reflected CRC-32; a good frame incl. FCS leaves 32'hDEBB20E3
    function automatic logic [31:0] crc_ref(input byte unsigned q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    byte unsigned frm[$];

    task automatic build_frame(input int plen);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
        fcs = ~crc_ref(frm);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic send_bit(input logic b);
        rx = ~b;
        repeat (HALF_BIT) @(negedge clk);
        rx = b;
        repeat (HALF_BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) send_byte(8'h55, 8);
        send_byte(8'hD5, 8);
    endtask

    task automatic run_frame(input string tag, input byte unsigned q[$], input int dribble);
        int   e0, lp0, exp_n, mism;
        logic exp_err, exp_ok;
        rx_q.delete();
        sof_bad = 0;
        e0  = eof_cnt;
        lp0 = lp_cnt;
        send_preamble();
        foreach (q[i]) send_byte(q[i], 8);
        if (dribble > 0) send_byte(8'($urandom), dribble);
        rx = 1'b0;
        repeat (40) @(negedge clk);

        exp_n   = (q.size() > MAX_LEN) ? MAX_LEN : q.size();
        exp_err = (q.size() > MAX_LEN) || (dribble != 0);
        exp_ok  = !exp_err && (q.size() >= 5) && (crc_ref(q) == 32'hDEBB20E3);
        mism = 0;
        for (int i = 0; i < exp_n && i < rx_q.size(); i++) if (rx_q[i] != q[i]) mism++;

        check_eq({tag, ".eof_cnt"}, eof_cnt - e0, 1);
        check_eq({tag, ".nbytes"}, rx_q.size(), exp_n);
        check_eq({tag, ".data"}, mism, 0);
        check_eq({tag, ".sof"}, sof_bad, 0);
        check_eq({tag, ".len"}, eof_len, exp_n);
        check_eq({tag, ".crc_ok"}, eof_ok, exp_ok);
        check_eq({tag, ".err"}, eof_err, exp_err);
        check_eq({tag, ".no_nlp"}, lp_cnt - lp0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte unsigned tq[$];
        int e0, lp0, plen, dr, bi;

        rx = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst.valid", rx_valid, 0);
        check_eq("rst.data", rx_data, 0);
        check_eq("rst.eof", rx_eof, 0);
        check_eq("rst.len", rx_len, 0);
        check_eq("rst.lp", link_pulse, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("idle.eof_cnt", eof_cnt, 0);

        // 1: 60-byte payload + FCS
        build_frame(60);
        run_frame("t1", frm, 0);

        // 2: same frame, byte 20 bit 3 flipped
        tq = frm;
        tq[20] = tq[20] ^ 8'h08;
        run_frame("t2", tq, 0);

        // 3: isolated link pulse
        rx_q.delete();
        e0 = eof_cnt;
        lp0 = lp_cnt;
        rx = 1'b1;
        repeat (HALF_BIT) @(negedge clk);
        rx = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("t3.nlp", lp_cnt - lp0, 1);
        check_eq("t3.no_eof", eof_cnt - e0, 0);
        check_eq("t3.no_valid", rx_q.size(), 0);

        // 4: truncated 3 bits into byte 10
        build_frame(60);
        tq = frm[0:9];
        run_frame("t4", tq, 3);

        // 5: reset during byte 20, then a clean frame
        build_frame(60);
        rx_q.delete();
        e0 = eof_cnt;
        send_preamble();
        for (int i = 0; i < 20; i++) send_byte(frm[i], 8);
        send_byte(frm[20], 3);
        rst_n = 1'b0;
        rx = 1'b0;
        #1;
        check_eq("t5.valid", rx_valid, 0);
        check_eq("t5.data", rx_data, 0);
        check_eq("t5.len", rx_len, 0);
        check_eq("t5.sof", rx_sof, 0);
        check_eq("t5.before", rx_q.size(), 20);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t5.no_eof", eof_cnt - e0, 0);
        check_eq("t5.no_more", rx_q.size(), 20);
        build_frame(40);
        run_frame("t5b", frm, 0);

        // 6: length boundaries around MAX_LEN, then recovery
        build_frame(MAX_LEN - 4);
        run_frame("t6_max", frm, 0);
        build_frame(MAX_LEN - 3);
        run_frame("t6_over", frm, 0);
        build_frame(30);
        run_frame("t6_next", frm, 0);

        // Short-frame boundary: 4 bytes never OK, 5 bytes can be
        build_frame(0);
        run_frame("short4", frm, 0);
        build_frame(1);
        run_frame("short5", frm, 0);

        // Randomized frames: random length, occasional corruption or dribble
        for (int k = 0; k < 6; k++) begin
            plen = $urandom_range(0, 30);
            build_frame(plen);
            if ($urandom_range(0, 2) == 0) begin
                bi = $urandom_range(0, frm.size() - 1);
                frm[bi] = frm[bi] ^ (8'd1 << $urandom_range(0, 7));
            end
            dr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            run_frame($sformatf("rnd%0d", k), frm, dr);
        end

        check_eq("valid_eof_overlap", overlap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
